// File: rtl/ntt_pkg.sv
// Shared NTT definitions: buffer state encoding and bit-reversal helper
// used by the coefficient buffer, the NTT top and twiddle ROM addressing.
package ntt_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY,
    ST_FILL,
    ST_FULL,
    ST_DRAIN
  } state_t;

  // Reverses the low 'width' bits of value; bits at and above 'width' come back as zero.
  function automatic logic [31:0] bitrev(input logic [31:0] value, input int unsigned width);
    logic [31:0] r;
    r = '0;
    for (int unsigned i = 0; i < 32; i++) begin
      if (i < width) r[5'(width - 1 - i)] = value[5'(i)];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_bitrev_addr.sv
// Combinational bit reversal of a WIDTH-bit address.
module ntt_bitrev_addr
  import ntt_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [WIDTH-1:0] i_addr,
  output logic [WIDTH-1:0] o_addr
);

  always_comb begin
    o_addr = WIDTH'(bitrev(32'(i_addr), WIDTH));
  end

endmodule

// File: rtl/ntt_coeff_buffer.sv
// N-coefficient register buffer: serial fill (natural or bit-reversed order),
// parallel view and write-back for the butterflies, serial natural-order drain.
module ntt_coeff_buffer
  import ntt_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 16,
  parameter int unsigned N          = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    bitrev_en,
  input  logic                    s_valid,
  output logic                    s_ready,
  input  logic [DATA_WIDTH-1:0]   s_data,
  input  logic                    par_load,
  input  logic [N*DATA_WIDTH-1:0] par_din,
  output logic [N*DATA_WIDTH-1:0] par_dout,
  output logic                    full,
  input  logic                    drain_start,
  output logic                    m_valid,
  input  logic                    m_ready,
  output logic [DATA_WIDTH-1:0]   m_data,
  output logic                    m_last
);

  localparam int unsigned      LOG2N = $clog2(N);
  localparam logic [LOG2N-1:0] LAST  = LOG2N'(N - 1);

  state_t                           r_state;
  logic [LOG2N-1:0]                 r_wr_cnt;
  logic [LOG2N-1:0]                 r_rd_cnt;
  logic                             r_mode;
  logic [N-1:0][DATA_WIDTH-1:0]     r_mem;

  logic [LOG2N-1:0]                 w_wr_rev;
  logic [LOG2N-1:0]                 w_wr_addr;
  logic [N-1:0][DATA_WIDTH-1:0]     w_par_din;

  assign w_par_din = par_din;

  ntt_bitrev_addr #(.WIDTH(LOG2N)) u_bitrev (
    .i_addr (r_wr_cnt),
    .o_addr (w_wr_rev)
  );

  assign w_wr_addr = r_mode ? w_wr_rev : r_wr_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= ST_EMPTY;
      r_wr_cnt <= '0;
      r_rd_cnt <= '0;
      r_mode   <= 1'b0;
      r_mem    <= '0;
    end else begin
      case (r_state)
        ST_EMPTY: begin
          if (par_load) begin
            r_mem   <= w_par_din;
            r_state <= ST_FULL;
          end else if (s_valid) begin
            // addr(0) is 0 in either order, so the first word needs no reversal
            r_mem[0] <= s_data;
            r_mode   <= bitrev_en;
            r_wr_cnt <= LOG2N'(1);
            r_state  <= ST_FILL;
          end
        end
        ST_FILL: begin
          if (s_valid) begin
            r_mem[w_wr_addr] <= s_data;
            if (r_wr_cnt == LAST) begin
              r_wr_cnt <= '0;
              r_state  <= ST_FULL;
            end else begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
          end
        end
        ST_FULL: begin
          if (par_load) begin
            r_mem <= w_par_din;
          end else if (drain_start) begin
            r_rd_cnt <= '0;
            r_state  <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          if (m_ready) begin
            if (r_rd_cnt == LAST) begin
              r_rd_cnt <= '0;
              r_state  <= ST_EMPTY;
            end else begin
              r_rd_cnt <= r_rd_cnt + 1'b1;
            end
          end
        end
        default: r_state <= ST_EMPTY;
      endcase
    end
  end

  assign s_ready  = (r_state == ST_EMPTY) || (r_state == ST_FILL);
  assign full     = (r_state == ST_FULL);
  assign m_valid  = (r_state == ST_DRAIN);
  assign m_last   = (r_state == ST_DRAIN) && (r_rd_cnt == LAST);
  assign m_data   = (r_state == ST_DRAIN) ? r_mem[r_rd_cnt] : '0;
  assign par_dout = r_mem;

endmodule

// File: tb/tb_ntt_coeff_buffer.sv
// Bench for ntt_coeff_buffer: directed scenarios plus random traffic checked
// every cycle against a queue/array model; a second N=2 instance covers the small build.
module tb_ntt_coeff_buffer;

  localparam int DW = 16;
  localparam int NN = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                 rst_n = 1'b0;
  logic                 bitrev_en = 1'b0;
  logic                 s_valid = 1'b0;
  logic                 s_ready;
  logic [DW-1:0]        s_data = '0;
  logic                 par_load = 1'b0;
  logic [NN-1:0][DW-1:0] par_din = '0;
  logic [NN-1:0][DW-1:0] par_dout;
  logic                 full;
  logic                 drain_start = 1'b0;
  logic                 m_valid;
  logic                 m_ready = 1'b0;
  logic [DW-1:0]        m_data;
  logic                 m_last;

  ntt_coeff_buffer #(.DATA_WIDTH(DW), .N(NN)) dut (
    .clk(clk), .rst_n(rst_n), .bitrev_en(bitrev_en),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .par_load(par_load), .par_din(par_din), .par_dout(par_dout),
    .full(full), .drain_start(drain_start),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_last(m_last)
  );

  logic        b_rst_n = 1'b0;
  logic        b_bitrev_en = 1'b0;
  logic        b_s_valid = 1'b0;
  logic        b_s_ready;
  logic [31:0] b_s_data = '0;
  logic        b_par_load = 1'b0;
  logic [63:0] b_par_din = '0;
  logic [63:0] b_par_dout;
  logic        b_full;
  logic        b_drain_start = 1'b0;
  logic        b_m_valid;
  logic        b_m_ready = 1'b0;
  logic [31:0] b_m_data;
  logic        b_m_last;

  ntt_coeff_buffer #(.DATA_WIDTH(32), .N(2)) dut2 (
    .clk(clk), .rst_n(b_rst_n), .bitrev_en(b_bitrev_en),
    .s_valid(b_s_valid), .s_ready(b_s_ready), .s_data(b_s_data),
    .par_load(b_par_load), .par_din(b_par_din), .par_dout(b_par_dout),
    .full(b_full), .drain_start(b_drain_start),
    .m_valid(b_m_valid), .m_ready(b_m_ready), .m_data(b_m_data), .m_last(b_m_last)
  );

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Behavioural model: phase, n-th fill word lands at perm(n), drain reads index rn.
  localparam int PE = 0, PF = 1, PU = 2, PD = 3;
  logic [DW-1:0] mm [NN];
  int ph = PE;
  int wn = 0;
  int rn = 0;
  bit mmode = 1'b0;

  function automatic int rev4(input int c);
    int r = 0;
    int v = c;
    for (int b = 0; b < 4; b++) begin
      r = r * 2 + (v % 2);
      v = v / 2;
    end
    return r;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NN; i++) mm[i] = '0;
    ph = PE; wn = 0; rn = 0; mmode = 1'b0;
  endtask

  task automatic model_step();
    case (ph)
      PE, PF: begin
        if (ph == PE && par_load) begin
          for (int i = 0; i < NN; i++) mm[i] = par_din[i];
          ph = PU;
        end else if (s_valid) begin
          if (wn == 0) mmode = bitrev_en;
          mm[mmode ? rev4(wn) : wn] = s_data;
          wn++;
          if (wn == NN) begin ph = PU; wn = 0; end
          else ph = PF;
        end
      end
      PU: begin
        if (par_load) begin
          for (int i = 0; i < NN; i++) mm[i] = par_din[i];
        end else if (drain_start) begin
          ph = PD; rn = 0;
        end
      end
      default: begin
        if (m_ready) begin
          rn++;
          if (rn == NN) begin ph = PE; rn = 0; end
        end
      end
    endcase
  endtask

  initial model_reset();
  always @(negedge rst_n) model_reset();
  always @(posedge clk) begin
    if (!rst_n) model_reset();
    else model_step();
  end

  always @(negedge clk) begin
    if (chk_en) begin
      logic [NN-1:0][DW-1:0] e;
      for (int i = 0; i < NN; i++) e[i] = mm[i];
      chk("cyc_s_ready", s_ready, (ph == PE) || (ph == PF));
      chk("cyc_full", full, ph == PU);
      chk("cyc_m_valid", m_valid, ph == PD);
      chk("cyc_m_last", m_last, (ph == PD) && (rn == NN - 1));
      chk("cyc_m_data", m_data, (ph == PD) ? mm[rn] : '0);
      chk("cyc_par_dout", par_dout, e);
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drain_all(input string name);
    drain_start = 1'b1;
    m_ready = 1'b1;
    tick();
    drain_start = 1'b0;
    for (int c = 0; c < 40 && !s_ready; c++) tick();
    m_ready = 1'b0;
    chk(name, s_ready, 1'b1);
  endtask

  initial begin
    #1000000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    logic [DW-1:0] got_w [NN];
    int got, lastpos, lastcnt;
    logic [DW-1:0] held;
    bit stalled;

    repeat (2) @(posedge clk);
    #2;
    chk("rst_s_ready", s_ready, 1'b1);
    chk("rst_full", full, 1'b0);
    chk("rst_m_valid", m_valid, 1'b0);
    chk("rst_m_last", m_last, 1'b0);
    chk("rst_m_data", m_data, '0);
    chk("rst_par_dout", par_dout, '0);
    rst_n = 1'b1;
    b_rst_n = 1'b1;
    chk_en = 1'b1;

    // 1: natural fill of 1..16
    for (int i = 0; i < NN; i++) begin
      chk("t1_not_full", full, 1'b0);
      s_valid = 1'b1; s_data = DW'(i + 1);
      tick();
    end
    s_valid = 1'b0;
    chk("t1_full", full, 1'b1);
    for (int k = 0; k < NN; k++) chk("t1_word", par_dout[k], k + 1);

    // 3: drain with m_ready pattern 1,0,0,1
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0;
    got = 0; lastpos = -1; lastcnt = 0; stalled = 1'b0; held = '0;
    for (int c = 0; c < 200 && got < NN; c++) begin
      m_ready = ((c % 4) == 0) || ((c % 4) == 3);
      if (stalled) chk("t3_stall_hold", m_data, held);
      if (m_valid && m_ready) begin
        got_w[got] = m_data;
        if (m_last) begin lastcnt++; lastpos = got; end
        got++;
      end
      stalled = m_valid && !m_ready;
      held = m_data;
      tick();
    end
    m_ready = 1'b0;
    chk("t3_count", got, NN);
    for (int j = 0; j < NN; j++) chk("t3_word", got_w[j], j + 1);
    chk("t3_last_cnt", lastcnt, 1);
    chk("t3_last_pos", lastpos, NN - 1);
    chk("t3_empty", s_ready, 1'b1);

    // 2: bit-reversed fill, bitrev_en toggled after the first word
    for (int i = 0; i < NN; i++) begin
      bitrev_en = (i == 0) ? 1'b1 : 1'(i % 2);
      s_valid = 1'b1; s_data = DW'(i);
      tick();
    end
    s_valid = 1'b0; bitrev_en = 1'b0;
    chk("t2_full", full, 1'b1);
    chk("t2_word1", par_dout[1], 8);
    chk("t2_word2", par_dout[2], 4);
    chk("t2_word15", par_dout[15], 15);
    chk("t2_word0", par_dout[0], 0);

    // 4: par_load beats drain_start in FULL
    for (int k = 0; k < NN; k++) par_din[k] = DW'(100 + k);
    par_load = 1'b1; drain_start = 1'b1;
    tick();
    par_load = 1'b0; drain_start = 1'b0;
    chk("t4_full", full, 1'b1);
    chk("t4_no_drain", m_valid, 1'b0);
    for (int k = 0; k < NN; k++) chk("t4_word", par_dout[k], 100 + k);
    drain_all("t4_drained");

    // 5: reset mid-fill, then a clean fill
    for (int i = 0; i < 7; i++) begin
      s_valid = 1'b1; s_data = DW'(50 + i);
      tick();
    end
    s_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("t5_s_ready", s_ready, 1'b1);
    chk("t5_full", full, 1'b0);
    chk("t5_par_dout", par_dout, '0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < NN; i++) begin
      s_valid = 1'b1; s_data = DW'(200 + i);
      tick();
    end
    s_valid = 1'b0;
    chk("t5_refill_full", full, 1'b1);
    chk("t5_refill_w0", par_dout[0], 200);
    chk("t5_refill_w15", par_dout[15], 215);
    drain_all("t5_drained");

    // random traffic, checked each cycle by the model
    for (int c = 0; c < 3000; c++) begin
      s_valid = 1'($urandom_range(0, 1));
      s_data = DW'($urandom);
      bitrev_en = 1'($urandom_range(0, 1));
      par_load = ($urandom_range(0, 15) == 0);
      for (int k = 0; k < NN; k++) par_din[k] = DW'($urandom);
      drain_start = ($urandom_range(0, 3) == 0);
      m_ready = 1'($urandom_range(0, 1));
      tick();
    end
    s_valid = 1'b0; par_load = 1'b0; drain_start = 1'b0; m_ready = 1'b0;
    tick();

    // 6: N=2, DATA_WIDTH=32 instance
    chk("t6_rst_ready", b_s_ready, 1'b1);
    b_s_valid = 1'b1; b_s_data = 32'hDEADBEEF;
    tick();
    chk("t6_mid_full", b_full, 1'b0);
    b_s_data = 32'h1;
    tick();
    b_s_valid = 1'b0;
    chk("t6_full", b_full, 1'b1);
    chk("t6_par_dout", b_par_dout, 64'h00000001_DEADBEEF);
    b_drain_start = 1'b1;
    tick();
    b_drain_start = 1'b0;
    b_m_ready = 1'b1;
    chk("t6_v0", b_m_valid, 1'b1);
    chk("t6_d0", b_m_data, 32'hDEADBEEF);
    chk("t6_l0", b_m_last, 1'b0);
    tick();
    chk("t6_v1", b_m_valid, 1'b1);
    chk("t6_d1", b_m_data, 32'h1);
    chk("t6_l1", b_m_last, 1'b1);
    tick();
    b_m_ready = 1'b0;
    chk("t6_done_valid", b_m_valid, 1'b0);
    chk("t6_done_ready", b_s_ready, 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
